// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem reads, and holds one fetched
// instruction for decode behind a valid/ready handshake. Handles redirects and halt.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic [31:0] imemload,
   input  logic        ihit,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redir_en,
   input  logic [31:0] redir_pc,
   output logic        halt,
   output logic [31:0] instr_count
);

   typedef enum logic [1:0] {FETCH, HALT_PEND, DONE} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] instr_n, instr_pc_n, instr_count_n;
   logic        instr_valid_n, halt_n;
   logic        accept, can_load;

   assign accept   = instr_valid & instr_ready;
   assign can_load = ~instr_valid | accept;
   assign imemaddr = pc;
   assign pc_plus4 = instr_pc + 32'd4;
   assign imemREN  = ~RST & (state == FETCH) & can_load;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         halt        <= 1'b0;
         instr_count <= '0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         instr       <= instr_n;
         instr_pc    <= instr_pc_n;
         instr_valid <= instr_valid_n;
         halt        <= halt_n;
         instr_count <= instr_count_n;
      end
   end

   always_comb begin
      state_n       = state;
      pc_n          = pc;
      instr_n       = instr;
      instr_pc_n    = instr_pc;
      instr_valid_n = instr_valid & ~accept;
      halt_n        = halt;
      // An accept is counted even when a redirect squashes the buffer the same cycle.
      instr_count_n = instr_count + {31'b0, accept};
      unique case (state)
         FETCH: begin
            if (redir_en) begin
               pc_n          = {redir_pc[31:2], 2'b00};
               instr_valid_n = 1'b0;
            end else if (ihit && can_load) begin
               instr_n       = imemload;
               instr_pc_n    = pc;
               instr_valid_n = 1'b1;
               if (imemload == HALT_WORD) state_n = HALT_PEND;
               else                       pc_n    = pc + 32'd4;
            end
         end
         HALT_PEND: begin
            if (redir_en) begin
               pc_n          = {redir_pc[31:2], 2'b00};
               instr_valid_n = 1'b0;
               state_n       = FETCH;
            end else if (accept) begin
               instr_valid_n = 1'b0;
               halt_n        = 1'b1;
               state_n       = DONE;
            end
         end
         DONE: begin
            instr_valid_n = 1'b0;
            halt_n        = 1'b1;
         end
         default: state_n = FETCH;
      endcase
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the fetch stage.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST, ihit, instr_ready, redir_en;
   logic [31:0] imemload, redir_pc;
   logic        imemREN, instr_valid, halt;
   logic [31:0] imemaddr, instr, instr_pc, pc_plus4, instr_count;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [31:0] halt_addr = 32'h1;
   logic [31:0] m_pc, m_instr, m_ipc, m_count;
   logic        m_valid, m_halt;
   int          m_mode;   // 0 fetching, 1 halt word waiting, 2 halted
   logic        exp_ren, obs_ren;

   fetch_unit #(.RESET_PC(32'h0000_0000), .HALT_WORD(32'hFFFF_FFFF)) dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload),
      .ihit(ihit), .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .redir_en(redir_en),
      .redir_pc(redir_pc), .halt(halt), .instr_count(instr_count)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem(input logic [31:0] a);
      logic [31:0] w;
      if (a == halt_addr) return 32'hFFFF_FFFF;
      case (a)
         32'h0:   w = 32'h2403_0017;
         32'h4:   w = 32'h2401_0071;
         32'h8:   w = 32'h0061_1021;
         default: w = (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
      endcase
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      return w;
   endfunction

   // Drives one cycle, samples imemREN before the edge, then advances the model.
   task automatic step(input logic r, input logic h, input logic rd, input logic re,
                       input logic [31:0] rp);
      logic [31:0] word;
      logic        acc;
      RST = r; ihit = h; instr_ready = rd; redir_en = re; redir_pc = rp;
      word     = mem(m_pc);
      imemload = h ? word : 32'hDEAD_BEEF;
      exp_ren  = !r && (m_mode == 0) && (!m_valid || rd);
      #2 obs_ren = imemREN;
      @(posedge CLK);
      if (r) begin
         m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0;
         m_halt = 1'b0; m_count = 32'h0; m_mode = 0;
      end else begin
         acc = m_valid && rd;
         if (acc) m_count = m_count + 1;
         if (m_mode == 2) begin
         end else if (re) begin
            m_pc = rp & 32'hFFFF_FFFC; m_valid = 1'b0; m_mode = 0;
         end else if (m_mode == 1) begin
            if (acc) begin m_valid = 1'b0; m_halt = 1'b1; m_mode = 2; end
         end else begin
            if (acc) m_valid = 1'b0;
            if (h && !m_valid) begin
               m_instr = word; m_ipc = m_pc; m_valid = 1'b1;
               if (word == 32'hFFFF_FFFF) m_mode = 1;
               else                       m_pc = m_pc + 4;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      step(1, 1, 1, 0, 0);
      n_cmp++; if (obs_ren !== 1'b0) begin n_err++; $display("FAIL rst_ren actual=%b required=0", obs_ren); end
      step(1, 0, 0, 0, 0);
      n_cmp++; if (imemaddr !== 32'h0) begin n_err++; $display("FAIL rst_pc actual=%h required=0", imemaddr); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid actual=%b required=0", instr_valid); end
      n_cmp++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_buf actual=%h/%h required=0/0", instr, instr_pc); end
      n_cmp++; if (halt !== 1'b0 || instr_count !== 32'h0) begin n_err++; $display("FAIL rst_halt_cnt actual=%b/%0d required=0/0", halt, instr_count); end
   endtask

   task automatic test_straight_line();
      logic [31:0] exp_w [3];
      exp_w[0] = 32'h2403_0017; exp_w[1] = 32'h2401_0071; exp_w[2] = 32'h0061_1021;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 0, 0);
         n_cmp++; if (obs_ren !== 1'b1) begin n_err++; $display("FAIL sl_ren%0d actual=%b required=1", i, obs_ren); end
         n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i)) begin n_err++; $display("FAIL sl_pc%0d actual=%b/%h required=1/%h", i, instr_valid, instr_pc, 4 * i); end
         n_cmp++; if (instr !== exp_w[i]) begin n_err++; $display("FAIL sl_instr%0d actual=%h required=%h", i, instr, exp_w[i]); end
         n_cmp++; if (pc_plus4 !== 32'(4 * i + 4)) begin n_err++; $display("FAIL sl_pcp4_%0d actual=%h required=%h", i, pc_plus4, 4 * i + 4); end
      end
      step(0, 1, 1, 0, 0);
      n_cmp++; if (instr_count !== 32'd3) begin n_err++; $display("FAIL sl_count actual=%0d required=3", instr_count); end
      n_cmp++; if (imemaddr !== 32'h10) begin n_err++; $display("FAIL sl_next_pc actual=%h required=10", imemaddr); end
   endtask

   task automatic test_wait_states();
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 1, 0, 0);
         n_cmp++; if (obs_ren !== 1'b1) begin n_err++; $display("FAIL ws_ren%0d actual=%b required=1", i, obs_ren); end
         n_cmp++; if (imemaddr !== 32'h10 || instr_valid !== 1'b0) begin n_err++; $display("FAIL ws_hold%0d actual=%h/%b required=10/0", i, imemaddr, instr_valid); end
      end
      step(0, 1, 1, 0, 0);
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr !== mem(32'h10)) begin n_err++; $display("FAIL ws_load actual=%b/%h/%h required=1/10/%h", instr_valid, instr_pc, instr, mem(32'h10)); end
   endtask

   task automatic test_backpressure();
      logic [31:0] cnt0;
      cnt0 = instr_count;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 0);
         n_cmp++; if (obs_ren !== 1'b0) begin n_err++; $display("FAIL bp_ren%0d actual=%b required=0", i, obs_ren); end
         n_cmp++; if (imemaddr !== 32'h14 || instr_pc !== 32'h10 || instr !== mem(32'h10)) begin n_err++; $display("FAIL bp_stable%0d actual=%h/%h/%h required=14/10/%h", i, imemaddr, instr_pc, instr, mem(32'h10)); end
      end
      step(0, 1, 1, 0, 0);
      n_cmp++; if (obs_ren !== 1'b1) begin n_err++; $display("FAIL bp_release_ren actual=%b required=1", obs_ren); end
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h14 || instr_count !== cnt0 + 1) begin n_err++; $display("FAIL bp_release actual=%b/%h/%0d required=1/14/%0d", instr_valid, instr_pc, instr_count, cnt0 + 1); end
   endtask

   task automatic test_redirect();
      step(0, 1, 1, 1, 32'h0000_0016);
      n_cmp++; if (imemaddr !== 32'h14 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rd_squash actual=%h/%b required=14/0", imemaddr, instr_valid); end
      n_cmp++; if (instr_count !== m_count) begin n_err++; $display("FAIL rd_count actual=%0d required=%0d", instr_count, m_count); end
      step(0, 1, 1, 0, 0);
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h14) begin n_err++; $display("FAIL rd_refetch actual=%b/%h required=1/14", instr_valid, instr_pc); end
   endtask

   task automatic test_halt();
      halt_addr = 32'h28;
      step(0, 1, 1, 1, 32'h20);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
      n_cmp++; if (instr !== 32'hFFFF_FFFF || instr_pc !== 32'h28 || imemaddr !== 32'h28) begin n_err++; $display("FAIL ht_load actual=%h/%h/%h required=ffffffff/28/28", instr, instr_pc, imemaddr); end
      step(0, 1, 0, 0, 0);
      n_cmp++; if (obs_ren !== 1'b0) begin n_err++; $display("FAIL ht_pend_ren actual=%b required=0", obs_ren); end
      n_cmp++; if (imemaddr !== 32'h28 || halt !== 1'b0 || instr_valid !== 1'b1) begin n_err++; $display("FAIL ht_pend actual=%h/%b/%b required=28/0/1", imemaddr, halt, instr_valid); end
      step(0, 1, 1, 0, 0);
      n_cmp++; if (halt !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL ht_done actual=%b/%b required=1/0", halt, instr_valid); end
      step(0, 1, 1, 1, 32'h80);
      n_cmp++; if (obs_ren !== 1'b0) begin n_err++; $display("FAIL ht_done_ren actual=%b required=0", obs_ren); end
      n_cmp++; if (halt !== 1'b1 || imemaddr !== 32'h28 || instr_valid !== 1'b0) begin n_err++; $display("FAIL ht_ignore_redir actual=%b/%h/%b required=1/28/0", halt, imemaddr, instr_valid); end
   endtask

   task automatic test_wrap();
      step(1, 0, 0, 0, 0);
      n_cmp++; if (halt !== 1'b0 || imemaddr !== 32'h0 || instr_count !== 32'h0) begin n_err++; $display("FAIL wr_reset_exit actual=%b/%h/%0d required=0/0/0", halt, imemaddr, instr_count); end
      step(0, 1, 1, 1, 32'hFFFF_FFFF);
      n_cmp++; if (imemaddr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_redir actual=%h required=fffffffc", imemaddr); end
      step(0, 1, 1, 0, 0);
      n_cmp++; if (instr_pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || imemaddr !== 32'h0) begin n_err++; $display("FAIL wr_wrap actual=%h/%h/%h required=fffffffc/0/0", instr_pc, pc_plus4, imemaddr); end
   endtask

   task automatic test_halt_pend_redirect();
      halt_addr = 32'h28;
      step(0, 0, 1, 1, 32'h28);
      step(0, 1, 0, 0, 0);
      n_cmp++; if (instr !== 32'hFFFF_FFFF || instr_valid !== 1'b1) begin n_err++; $display("FAIL hp_load actual=%h/%b required=ffffffff/1", instr, instr_valid); end
      step(0, 1, 0, 1, 32'h40);
      n_cmp++; if (instr_valid !== 1'b0 || halt !== 1'b0 || imemaddr !== 32'h40) begin n_err++; $display("FAIL hp_redir actual=%b/%b/%h required=0/0/40", instr_valid, halt, imemaddr); end
      step(0, 1, 1, 0, 0);
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== mem(32'h40)) begin n_err++; $display("FAIL hp_resume actual=%b/%h/%h required=1/40/%h", instr_valid, instr_pc, instr, mem(32'h40)); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
      step(1, 1, 1, 1, 32'h100);
      n_cmp++; if (imemaddr !== 32'h0 || instr_valid !== 1'b0 || instr_count !== 32'h0 || halt !== 1'b0) begin n_err++; $display("FAIL rm_state actual=%h/%b/%0d/%b required=0/0/0/0", imemaddr, instr_valid, instr_count, halt); end
      n_cmp++; if (obs_ren !== 1'b0) begin n_err++; $display("FAIL rm_ren actual=%b required=0", obs_ren); end
   endtask

   task automatic test_random();
      logic        r, h, rd, re;
      logic [31:0] rp;
      halt_addr = 32'h140;
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom % 60) == 0;
         h  = ($urandom % 4) != 0;
         rd = ($urandom % 3) != 0;
         re = ($urandom % 14) == 0;
         rp = (($urandom % 8) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                    : 32'h100 + $urandom_range(0, 96);
         step(r, h, rd, re, rp);
         n_cmp++; if (obs_ren !== exp_ren) begin n_err++; $display("FAIL rnd_ren@%0d actual=%b required=%b", i, obs_ren, exp_ren); end
         n_cmp++; if (imemaddr !== m_pc) begin n_err++; $display("FAIL rnd_pc@%0d actual=%h required=%h", i, imemaddr, m_pc); end
         n_cmp++; if (instr_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid@%0d actual=%b required=%b", i, instr_valid, m_valid); end
         n_cmp++; if (halt !== m_halt || instr_count !== m_count) begin n_err++; $display("FAIL rnd_halt_cnt@%0d actual=%b/%0d required=%b/%0d", i, halt, instr_count, m_halt, m_count); end
         if (m_valid) begin
            n_cmp++; if (instr !== m_instr || instr_pc !== m_ipc || pc_plus4 !== m_ipc + 32'd4) begin n_err++; $display("FAIL rnd_buf@%0d actual=%h/%h/%h required=%h/%h/%h", i, instr, instr_pc, pc_plus4, m_instr, m_ipc, m_ipc + 32'd4); end
         end
      end
   endtask

   initial begin
      RST = 1'b1; ihit = 1'b0; instr_ready = 1'b0; redir_en = 1'b0;
      redir_pc = 32'h0; imemload = 32'h0;
      m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_count = 32'h0;
      m_valid = 1'b0; m_halt = 1'b0; m_mode = 0;
      @(posedge CLK); #1;
      test_reset();
      test_straight_line();
      test_wait_states();
      test_backpressure();
      test_redirect();
      test_halt();
      test_wrap();
      test_halt_pend_redirect();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
